riscv_pipe_skid_register: RTL

Generic elastic pipeline stage register for the pipelined RV32I core. It replaces the fixed-field, enable/clear-style stage registers with a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered o_ready. Flush is synchronous and squashes control fields without touching data. A saturating back-pressure counter supports performance debug. It is instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with control and data fields packed by the instantiating stage.

---
 rtl/riscv_pipe_skid_register.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/riscv_pipe_skid_register.sv
// Elastic valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush of control fields and a saturating back-pressure counter.
module riscv_pipe_skid_register #(
  parameter int unsigned       CTRL_W    = 16,
  parameter int unsigned       DATA_W    = 160,
  parameter logic [CTRL_W-1:0] CTRL_INIT = '0,
  parameter bit                SKID_EN   = 1'b1,
  parameter bit                DATA_CLR  = 1'b0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_flush,
  input  logic              i_cnt_clr,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic                ready_q;
  logic [CTRL_W-1:0]   main_ctrl;
  logic [DATA_W-1:0]   main_data;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic [DATA_W-1:0]   skid_data;
  logic [CNT_W-1:0]    stall_cnt;
  logic                load_main;
  logic                load_skid;
  logic                main_from_skid;
  logic                in_fire;
  logic                out_fire;

  assign o_valid  = (state_q != EMPTY);
  assign o_ready  = SKID_EN ? ready_q : (!o_valid || i_ready);
  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;
  assign o_ctrl   = o_valid ? main_ctrl : CTRL_INIT;
  assign o_data   = main_data;
  assign o_stall_cnt = stall_cnt;

  // Occupancy is a straight decode of the held-entry state.
  always_comb begin
    o_occupancy = 2'd0;
    case (state_q)
      BUSY:    o_occupancy = 2'd1;
      FULL:    o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  // State register; o_ready is registered from the next state so it never depends on i_ready.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
    end
  end

  // Next-state and register load selects; flush overrides every handshake outcome.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          if (SKID_EN) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else begin
            load_main = 1'b1;
          end
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d        = BUSY;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (i_flush) begin
      state_d        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // Main and skid entry storage; flush squashes control and optionally data.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      main_ctrl <= CTRL_INIT;
      main_data <= '0;
      skid_ctrl <= CTRL_INIT;
      skid_data <= '0;
    end else if (i_flush) begin
      main_ctrl <= CTRL_INIT;
      skid_ctrl <= CTRL_INIT;
      if (DATA_CLR) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (load_main) begin
        main_ctrl <= i_ctrl;
        main_data <= i_data;
      end else if (main_from_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= i_ctrl;
        skid_data <= i_data;
      end
    end
  end

  // Saturating count of back-pressured cycles; clear wins over increment.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      stall_cnt <= '0;
    end else if (o_valid && !i_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
